// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared width default, drain FSM states and lane slicing helper
package systolic_pkg;

    localparam int DATA_BITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LANE = 2'd1,
        SEND      = 2'd2
    } drain_state_t;

    // Low bit of lane k inside a flattened per-lane bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/drain_lane_slot.sv
// rtl/drain_lane_slot.sv - one-deep result holder for a single PE lane with drop detection
module drain_lane_slot #(
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 capture,
    input  logic                 drain,
    input  logic [DATA_BITS-1:0] c,
    output logic                 full,
    output logic [DATA_BITS-1:0] data,
    output logic                 drop
);

    logic load;

    // A slot being drained this cycle can accept the next result at the same time.
    assign load = capture & (~full | drain);
    assign drop = capture & full & ~drain;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (load) begin
                data <= c;
            end
            if (load) begin
                full <= 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - PE result capture and lane-ordered stream drain (option: DRAIN_OVERRUN_COUNT_EN)
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int N_LANES   = 4,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic [N_LANES-1:0]           i_finish,
    input  logic [N_LANES*DATA_BITS-1:0] i_c,
    output logic [DATA_BITS-1:0]         o_tdata,
    output logic                         o_tvalid,
    input  logic                         i_tready,
    output logic                         o_tlast,
    output logic                         o_busy,
    output logic                         o_overrun,
    input  logic                         i_clear_overrun
`ifdef DRAIN_OVERRUN_COUNT_EN
    ,
    output logic [7:0]                   o_overrun_count
`endif
);

    localparam int PTR_BITS = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [PTR_BITS-1:0] LAST_LANE = PTR_BITS'(N_LANES - 1);

    drain_state_t          state, next_state;
    logic [PTR_BITS-1:0]   ptr, next_ptr;
    logic [N_LANES-1:0]    full;
    logic [N_LANES-1:0]    drop;
    logic [N_LANES-1:0]    drain;
    logic [DATA_BITS-1:0]  slot [N_LANES];
    logic                  handshake;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        drain_lane_slot #(.DATA_BITS(DATA_BITS)) u_slot (
            .clk     (i_clock),
            .resetn  (i_reset),
            .capture (i_valid & i_finish[k]),
            .drain   (drain[k]),
            .c       (i_c[lane_lo(k, DATA_BITS) +: DATA_BITS]),
            .full    (full[k]),
            .data    (slot[k]),
            .drop    (drop[k])
        );
    end

    assign drain  = handshake ? (N_LANES'(1) << ptr) : '0;
    assign o_busy = |full;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
        end
    end

    // Slot contents cannot change while SEND waits on ready, so the beat stays stable.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        o_tvalid   = 1'b0;
        o_tdata    = '0;
        o_tlast    = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (|full) begin
                    next_state = WAIT_LANE;
                end
            end
            WAIT_LANE: begin
                if (full[ptr]) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                o_tvalid = 1'b1;
                o_tdata  = slot[ptr];
                o_tlast  = (ptr == LAST_LANE);
                if (i_tready) begin
                    handshake = 1'b1;
                    if (ptr == LAST_LANE) begin
                        next_ptr   = '0;
                        next_state = IDLE;
                    end else begin
                        next_ptr   = ptr + 1'b1;
                        next_state = WAIT_LANE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_ptr   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_overrun <= 1'b0;
        end else if (|drop) begin
            o_overrun <= 1'b1;
        end else if (i_clear_overrun) begin
            o_overrun <= 1'b0;
        end
    end

`ifdef DRAIN_OVERRUN_COUNT_EN
    logic [7:0] drop_count;
    logic [8:0] count_sum;

    always_comb begin
        drop_count = '0;
        for (int k = 0; k < N_LANES; k++) begin
            drop_count = drop_count + 8'(drop[k]);
        end
    end

    assign count_sum = {1'b0, o_overrun_count} + {1'b0, drop_count};

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_overrun_count <= '0;
        end else if (drop_count != 8'd0) begin
            o_overrun_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
        end else if (i_clear_overrun) begin
            o_overrun_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - scoreboard bench with per-lane expected queues and random traffic
module tb_systolic_result_drain;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [3:0]  i_finish = '0;
    logic [63:0] i_c = '0;
    logic        i_tready = 1'b0;
    logic        i_clear_overrun = 1'b0;
    logic [15:0] o_tdata;
    logic        o_tvalid, o_tlast, o_busy, o_overrun;
`ifdef DRAIN_OVERRUN_COUNT_EN
    logic [7:0]  o_overrun_count;
`endif

    always #5 clk = ~clk;

    systolic_result_drain #(.N_LANES(4), .DATA_BITS(16)) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .i_finish        (i_finish),
        .i_c             (i_c),
        .o_tdata         (o_tdata),
        .o_tvalid        (o_tvalid),
        .i_tready        (i_tready),
        .o_tlast         (o_tlast),
        .o_busy          (o_busy),
        .o_overrun       (o_overrun),
        .i_clear_overrun (i_clear_overrun)
`ifdef DRAIN_OVERRUN_COUNT_EN
        ,
        .o_overrun_count (o_overrun_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: each lane is a queue of results not yet streamed; beats leave in lane order.
    logic [15:0] lane_q [4][$];
    int          exp_ptr = 0;
    logic        exp_ovr = 1'b0;
    int          exp_cnt = 0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_busy();
        for (int k = 0; k < 4; k++) if (lane_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            int drops;
            chk("busy", {31'd0, o_busy}, {31'd0, model_busy()});
            chk("overrun", {31'd0, o_overrun}, {31'd0, exp_ovr});
`ifdef DRAIN_OVERRUN_COUNT_EN
            chk("overrun_count", {24'd0, o_overrun_count}, exp_cnt);
`endif
            if (prev_stall) begin
                chk("hold_valid", {31'd0, o_tvalid}, 32'd1);
                chk("hold_data", {16'd0, o_tdata}, {16'd0, prev_data});
                chk("hold_last", {31'd0, o_tlast}, {31'd0, prev_last});
            end
            if (o_tvalid) begin
                if (lane_q[exp_ptr].size() == 0) begin
                    chk("beat_unexpected", {31'd0, o_tvalid}, 32'd0);
                end else begin
                    chk("beat_data", {16'd0, o_tdata}, {16'd0, lane_q[exp_ptr][0]});
                    chk("beat_last", {31'd0, o_tlast}, (exp_ptr == 3) ? 32'd1 : 32'd0);
                end
            end
            if (i_reset) begin
                if (o_tvalid && i_tready && lane_q[exp_ptr].size() != 0) begin
                    void'(lane_q[exp_ptr].pop_front());
                    exp_ptr = (exp_ptr + 1) % 4;
                end
                drops = 0;
                for (int k = 0; k < 4; k++) begin
                    if (i_valid && i_finish[k]) begin
                        if (lane_q[k].size() == 0) lane_q[k].push_back(i_c[k*16 +: 16]);
                        else drops++;
                    end
                end
                if (drops != 0) begin
                    exp_ovr = 1'b1;
                    exp_cnt = (exp_cnt + drops > 255) ? 255 : exp_cnt + drops;
                end else if (i_clear_overrun) begin
                    exp_ovr = 1'b0;
                    exp_cnt = 0;
                end
                prev_stall = o_tvalid & ~i_tready;
                prev_data  = o_tdata;
                prev_last  = o_tlast;
            end else begin
                for (int k = 0; k < 4; k++) lane_q[k].delete();
                exp_ptr    = 0;
                exp_ovr    = 1'b0;
                exp_cnt    = 0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] f, input logic [63:0] cc,
                         input logic r, input logic clr);
        i_valid = v;
        i_finish = f;
        i_c = cc;
        i_tready = r;
        i_clear_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] lane_word(input int k, input logic [15:0] v);
        logic [63:0] w;
        w = '0;
        w[k*16 +: 16] = v;
        return w;
    endfunction

    task automatic feed_frame(input logic [15:0] base, input logic r);
        for (int k = 0; k < 4; k++) drive(1'b1, 4'(1 << k), lane_word(k, base * 16'(k + 1)), r, 1'b0);
    endtask

    task automatic wait_tvalid(input int max);
        int n = 0;
        while (!o_tvalid && n < max) begin
            drive(1'b0, 4'h0, 64'h0, i_tready, 1'b0);
            n++;
        end
        chk("wait_tvalid", {31'd0, o_tvalid}, 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (o_busy && n < max) begin
            drive(1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
            n++;
        end
        drive(1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
        chk("drain_done", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        repeat (3) drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, o_tlast}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_tdata", {16'd0, o_tdata}, 32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
        i_reset = 1'b1;
        mon_en = 1'b1;

        // Full frame, streaming freely.
        feed_frame(16'h0010, 1'b1);
        wait_idle(50);

        // Downstream stall on the first beat.
        feed_frame(16'h0010, 1'b0);
        wait_tvalid(20);
        repeat (5) drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        chk("stall_data", {16'd0, o_tdata}, 32'h0010);
        wait_idle(50);

        // Skewed finish: lane 2 first.
        drive(1'b1, 4'b0100, lane_word(2, 16'h0300), 1'b1, 1'b0);
        drive(1'b1, 4'b0001, lane_word(0, 16'h0100), 1'b1, 1'b0);
        drive(1'b1, 4'b0010, lane_word(1, 16'h0200), 1'b1, 1'b0);
        drive(1'b1, 4'b1000, lane_word(3, 16'h0400), 1'b1, 1'b0);
        wait_idle(50);

        // Overrun on lane 1 while stalled, then clear.
        drive(1'b1, 4'b0011, lane_word(0, 16'h0001) | lane_word(1, 16'h1111), 1'b0, 1'b0);
        drive(1'b1, 4'b0010, lane_word(1, 16'h7FFF), 1'b0, 1'b0);
        drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        chk("overrun_set", {31'd0, o_overrun}, 32'd1);
        drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        chk("overrun_clr", {31'd0, o_overrun}, 32'd0);
        drive(1'b1, 4'b1100, lane_word(2, 16'h2222) | lane_word(3, 16'h3333), 1'b1, 1'b0);
        wait_idle(50);

        // Lane-0 handshake coinciding with a new lane-0 capture.
        feed_frame(16'h000A, 1'b0);
        wait_tvalid(20);
        drive(1'b1, 4'b0001, lane_word(0, 16'h0055), 1'b1, 1'b0);
        repeat (12) drive(1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b1, 4'b1110, lane_word(1, 16'h0066) | lane_word(2, 16'h0077) | lane_word(3, 16'h0088),
              1'b1, 1'b0);
        wait_idle(50);
        chk("no_overrun_simul", {31'd0, o_overrun}, 32'd0);

        // Reset while sending with two lanes held.
        drive(1'b1, 4'b0011, lane_word(0, 16'hAAAA) | lane_word(1, 16'hBBBB), 1'b0, 1'b0);
        wait_tvalid(20);
        i_reset = 1'b0;
        drive(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
        i_reset = 1'b1;
        chk("rst_mid_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        feed_frame(16'h0101, 1'b1);
        wait_idle(50);

        // Random traffic against the lane-queue model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] f;
            for (int k = 0; k < 4; k++) f[k] = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 3) != 0, f, {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        repeat (20) drive(1'b0, 4'h0, 64'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
